// File: rtl/like_alu_pkg.sv
// rtl/like_alu_pkg.sv - shared op codes and default width for the like_alu datapath leaf
//
// Purpose: op-code constants (legacy likeALU select encoding) and the default
//          operand width, shared by like_alu and like_alu_addsub.
// Ports:   none (package).
// Config:  LIKE_ALU_FLAGS_EN is consumed by like_alu, not here.
package like_alu_pkg;

  localparam int LIKE_ALU_WIDTH = 5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/like_alu_addsub.sv
// rtl/like_alu_addsub.sv - combinational ripple adder/subtractor shared by ADD and SUB
//
// Purpose: o_sum = i_a + i_b (i_sub=0) or i_a + ~i_b + 1 (i_sub=1), built as an
//          explicit ripple-carry chain.
// Ports:   i_a, i_b [WIDTH-1:0] operands
//          i_sub               1 selects subtract
//          o_sum [WIDTH-1:0]   result mod 2^WIDTH
//          o_carry             carry out of the MSB (for SUB: 1 means no borrow)
//          o_ovf               two's complement overflow
module like_alu_addsub
  import like_alu_pkg::*;
#(
  parameter int WIDTH = LIKE_ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_c;

  // Subtract is A + ~B + 1: invert B and inject the +1 as carry-in.
  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_c[0] = i_sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ w_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & w_b[i]) | (w_c[i] & (i_a[i] ^ w_b[i]));
  end

  assign o_carry = w_c[WIDTH];
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign o_ovf   = w_c[WIDTH] ^ w_c[WIDTH-1];

endmodule

// File: rtl/like_alu.sv
// rtl/like_alu.sv - registered 4-function ALU (ADD/SUB/AND/OR), 1-cycle latency
//
// Purpose: selects ADD/SUB/AND/OR of inp_A/inp_B by select, registers the result
//          with a valid strobe. Result and flags hold while in_valid=0.
// Ports:   clk, rst (sync, active-high)
//          in_valid, inp_A/inp_B [WIDTH-1:0], select [1:0]
//          out [WIDTH-1:0], out_valid
//          carry, zero, ovf (only when LIKE_ALU_FLAGS_EN is defined)
// Config:  `define LIKE_ALU_FLAGS_EN to add the registered flag outputs.
module like_alu
  import like_alu_pkg::*;
#(
  parameter int WIDTH = LIKE_ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] inp_A,
  input  logic [WIDTH-1:0] inp_B,
  input  logic [1:0]       select,
`ifdef LIKE_ALU_FLAGS_EN
  output logic             carry,
  output logic             zero,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  logic [WIDTH-1:0] r_out;
  logic             r_valid;

  like_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a     (inp_A),
    .i_b     (inp_B),
    .i_sub   (select == OP_SUB),
    .o_sum   (w_sum),
    .o_carry (w_carry),
    .o_ovf   (w_ovf)
  );

  always_comb begin
    w_res = w_sum;
    case (select)
      OP_ADD:  w_res = w_sum;
      OP_SUB:  w_res = w_sum;
      OP_AND:  w_res = inp_A & inp_B;
      OP_OR:   w_res = inp_A | inp_B;
      default: w_res = w_sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_res;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;

`ifdef LIKE_ALU_FLAGS_EN
  logic r_carry;
  logic r_zero;
  logic r_ovf;
  logic w_is_arith;

  // select[1]=0 covers exactly ADD and SUB; logic ops report no carry/overflow.
  assign w_is_arith = ~select[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (in_valid) begin
      r_carry <= w_is_arith & w_carry;
      r_ovf   <= w_is_arith & w_ovf;
      r_zero  <= (w_res == '0);
    end
  end

  assign carry = r_carry;
  assign zero  = r_zero;
  assign ovf   = r_ovf;
`else
  logic w_unused_flags;
  assign w_unused_flags = w_carry ^ w_ovf;
`endif

endmodule

// File: tb/tb_like_alu.sv
// tb/tb_like_alu.sv - self-checking bench for like_alu with directed and random vectors
module tb_like_alu;
  import like_alu_pkg::*;

  localparam int W = 5;
  localparam int M = 1 << W;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] inp_A;
  logic [W-1:0] inp_B;
  logic [1:0]   select;
  logic [W-1:0] out;
  logic         out_valid;
`ifdef LIKE_ALU_FLAGS_EN
  logic         carry;
  logic         zero;
  logic         ovf;
`endif

  like_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inp_A     (inp_A),
    .inp_B     (inp_B),
    .select    (select),
`ifdef LIKE_ALU_FLAGS_EN
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf),
`endif
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: what the outputs must show after the next edge
  int e_out   = 0;
  int e_valid = 0;
  int e_carry = 0;
  int e_zero  = 0;
  int e_ovf   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  // apply one cycle of inputs, update the model, then check after the edge
  task automatic step(input int r, input int v, input int a, input int b, input int s);
    int raw;
    int sres;
    rst      = r[0];
    in_valid = v[0];
    inp_A    = a[W-1:0];
    inp_B    = b[W-1:0];
    select   = s[1:0];
    if (r != 0) begin
      e_out = 0; e_valid = 0; e_carry = 0; e_zero = 0; e_ovf = 0;
    end else if (v != 0) begin
      e_valid = 1;
      e_carry = 0;
      e_ovf   = 0;
      case (s)
        0: begin
          raw     = a + b;
          e_out   = raw % M;
          e_carry = (raw >= M) ? 1 : 0;
          sres    = to_signed(a) + to_signed(b);
          e_ovf   = (sres >= M / 2 || sres < -(M / 2)) ? 1 : 0;
        end
        1: begin
          e_out   = (a - b + M) % M;
          e_carry = (a >= b) ? 1 : 0;
          sres    = to_signed(a) - to_signed(b);
          e_ovf   = (sres >= M / 2 || sres < -(M / 2)) ? 1 : 0;
        end
        2: e_out = a & b;
        default: e_out = a | b;
      endcase
      e_zero = (e_out == 0) ? 1 : 0;
    end else begin
      e_valid = 0;
    end
    @(posedge clk);
    #1;
    check("out", int'(out), e_out);
    check("out_valid", int'(out_valid), e_valid);
`ifdef LIKE_ALU_FLAGS_EN
    check("carry", int'(carry), e_carry);
    check("zero", int'(zero), e_zero);
    check("ovf", int'(ovf), e_ovf);
`endif
  endtask

  typedef struct {
    int a;
    int b;
    int s;
    int exp_out;
  } vec_t;

  vec_t dir_vecs[$] = '{
    '{5'b01001, 5'b00111, 0, 5'b10000},
    '{5'b01001, 5'b00111, 1, 5'b00010},
    '{5'b01001, 5'b00111, 2, 5'b00001},
    '{5'b01001, 5'b00111, 3, 5'b01111},
    '{5'b10101, 5'b01100, 0, 5'b00001},
    '{5'b10101, 5'b01100, 1, 5'b01001},
    '{5'b10101, 5'b01100, 2, 5'b00100},
    '{5'b10101, 5'b01100, 3, 5'b11101},
    '{5'b00111, 5'b00111, 1, 5'b00000},
    '{5'b00000, 5'b00001, 1, 5'b11111}
  };

  initial begin
    // reset with in_valid asserted: reset must win
    step(1, 1, 5'b01001, 5'b00111, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 7, 3, 0);
    check("hold_after_reset", int'(out), 0);

    foreach (dir_vecs[i]) begin
      step(0, 1, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].s);
      check($sformatf("dir%0d_out", i), int'(out), dir_vecs[i].exp_out);
    end

`ifdef LIKE_ALU_FLAGS_EN
    step(0, 1, 5'b01001, 5'b00111, 0);
    check("spec_add_ovf", int'(ovf), 1);
    check("spec_add_carry", int'(carry), 0);
    step(0, 1, 5'b00111, 5'b00111, 1);
    check("spec_sub_zero", int'(zero), 1);
    check("spec_sub_carry", int'(carry), 1);
`endif

    // idle cycle: out holds the last result, valid drops
    step(0, 1, 5'b10101, 5'b01100, 3);
    step(0, 0, 1, 1, 0);
    check("idle_hold", int'(out), 5'b11101);

    // reset mid-stream discards the sample, then first result after one cycle
    step(0, 1, 3, 4, 0);
    step(1, 1, 9, 9, 0);
    step(0, 1, 6, 2, 1);
    check("post_reset_first", int'(out), 4);

    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 49) == 0) ? 1 : 0,
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
